// File: rtl/stream_pipe_reg.sv
// Elastic Depth-stage valid/ready pipeline register with synchronous flush and occupancy count.
// Optional macro STREAM_PIPE_REG_DATA_RESET_EN adds a synchronous reset of the data registers.
module stream_pipe_reg #(
  parameter type         dtype    = logic,
  parameter int unsigned Depth    = 2,
  parameter int unsigned CntWidth = (Depth > 0) ? $clog2(Depth + 1) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  dtype                data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output dtype                data_o,
  output logic [CntWidth-1:0] occ_o
);

  if (Depth == 0) begin : g_bypass
    // No storage: the stream passes straight through, only ready is gated by flush.
    logic unused_c;
    assign unused_c = clk_i ^ rst_ni;
    assign valid_o  = valid_i;
    assign data_o   = data_i;
    assign ready_o  = ready_i & ~flush_i;
    assign occ_o    = '0;
  end else begin : g_pipe
    logic [Depth-1:0]    valid_q;
    logic [Depth-1:0]    valid_d;
    logic [Depth-1:0]    in_v_c;
    logic [Depth-1:0]    load_c;
    logic [Depth:0]      rdy_c;
    logic                rdy_acc;
    logic [CntWidth-1:0] occ_c;
    dtype                data_q [Depth];
    dtype                in_d_c [Depth];

    // Ready chain runs from the output side back to the input; a stage accepts if empty or draining.
    always_comb begin
      rdy_c        = '0;
      rdy_acc      = ready_i;
      rdy_c[Depth] = ready_i;
      for (int k = int'(Depth) - 1; k >= 0; k--) begin
        rdy_acc  = ~valid_q[k] | rdy_acc;
        rdy_c[k] = rdy_acc;
      end
    end

    always_comb begin
      in_v_c    = '0;
      in_v_c[0] = valid_i & ~flush_i;
      in_d_c[0] = data_i;
      for (int k = 1; k < int'(Depth); k++) begin
        in_v_c[k] = valid_q[k-1];
        in_d_c[k] = data_q[k-1];
      end
    end

    always_comb begin
      valid_d = valid_q;
      load_c  = '0;
      for (int k = 0; k < int'(Depth); k++) begin
        if (rdy_c[k]) begin
          valid_d[k] = in_v_c[k];
          load_c[k]  = in_v_c[k];
        end
      end
      if (flush_i) valid_d = '0;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) valid_q <= '0;
      else         valid_q <= valid_d;
    end

    // Data only moves with a valid beat so empty slots never disturb held payloads.
    always_ff @(posedge clk_i) begin
`ifdef STREAM_PIPE_REG_DATA_RESET_EN
      if (!rst_ni) begin
        for (int k = 0; k < int'(Depth); k++) data_q[k] <= '0;
      end else begin
        for (int k = 0; k < int'(Depth); k++) begin
          if (load_c[k]) data_q[k] <= in_d_c[k];
        end
      end
`else
      for (int k = 0; k < int'(Depth); k++) begin
        if (load_c[k]) data_q[k] <= in_d_c[k];
      end
`endif
    end

    always_comb begin
      occ_c = '0;
      for (int k = 0; k < int'(Depth); k++) occ_c = occ_c + CntWidth'(valid_q[k]);
    end

    assign valid_o = valid_q[Depth-1];
    assign data_o  = data_q[Depth-1];
    assign ready_o = rdy_c[0] & ~flush_i;
    assign occ_o   = occ_c;
  end

endmodule

// File: tb/tb_stream_pipe_reg.sv
// Directed bench for stream_pipe_reg: Depth=3 vector table plus reset and Depth=0 sequences.
module tb_stream_pipe_reg;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  typedef struct {
    bit       v;
    bit [7:0] d;
    bit       r;
    bit       fl;
    bit       ev;
    bit [7:0] ed;
    bit       er;
    bit [1:0] eo;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, valid_in, ready_out, valid_out, ready_in;
  logic [7:0] data_in, data_out;
  logic [1:0] occ;

  logic       flush0, valid_in0, ready_out0, valid_out0, ready_in0;
  logic [7:0] data_in0, data_out0;
  logic [0:0] occ0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_pipe_reg #(.dtype(logic [7:0]), .Depth(3)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(ready_out),
    .data_i(data_in), .valid_o(valid_out), .ready_i(ready_in), .data_o(data_out), .occ_o(occ)
  );

  stream_pipe_reg #(.dtype(logic [7:0]), .Depth(0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush0), .valid_i(valid_in0), .ready_o(ready_out0),
    .data_i(data_in0), .valid_o(valid_out0), .ready_i(ready_in0), .data_o(data_out0), .occ_o(occ0)
  );

  function automatic vec_t mk(bit v, bit [7:0] d, bit r, bit fl, bit ev, bit [7:0] ed, bit er,
                              bit [1:0] eo);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.fl = fl; t.ev = ev; t.ed = ed; t.er = er; t.eo = eo;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  vec_t tbl[$];

  initial begin
    // streaming 0x01..0x08
    tbl.push_back(mk(H, 8'h01, H, L, L, 8'h00, H, 2'd0));
    tbl.push_back(mk(H, 8'h02, H, L, L, 8'h00, H, 2'd1));
    tbl.push_back(mk(H, 8'h03, H, L, L, 8'h00, H, 2'd2));
    tbl.push_back(mk(H, 8'h04, H, L, H, 8'h01, H, 2'd3));
    tbl.push_back(mk(H, 8'h05, H, L, H, 8'h02, H, 2'd3));
    tbl.push_back(mk(H, 8'h06, H, L, H, 8'h03, H, 2'd3));
    tbl.push_back(mk(H, 8'h07, H, L, H, 8'h04, H, 2'd3));
    tbl.push_back(mk(H, 8'h08, H, L, H, 8'h05, H, 2'd3));
    tbl.push_back(mk(L, 8'h00, H, L, H, 8'h06, H, 2'd3));
    tbl.push_back(mk(L, 8'h00, H, L, H, 8'h07, H, 2'd2));
    tbl.push_back(mk(L, 8'h00, H, L, H, 8'h08, H, 2'd1));
    tbl.push_back(mk(L, 8'h00, H, L, L, 8'h00, H, 2'd0));
    // backpressure fill then drain
    tbl.push_back(mk(H, 8'hA0, L, L, L, 8'h00, H, 2'd0));
    tbl.push_back(mk(H, 8'hA1, L, L, L, 8'h00, H, 2'd1));
    tbl.push_back(mk(H, 8'hA2, L, L, L, 8'h00, H, 2'd2));
    tbl.push_back(mk(H, 8'hA3, L, L, H, 8'hA0, L, 2'd3));
    tbl.push_back(mk(H, 8'hA3, L, L, H, 8'hA0, L, 2'd3));
    tbl.push_back(mk(H, 8'hA3, H, L, H, 8'hA0, H, 2'd3));
    tbl.push_back(mk(L, 8'h00, H, L, H, 8'hA1, H, 2'd3));
    tbl.push_back(mk(L, 8'h00, H, L, H, 8'hA2, H, 2'd2));
    tbl.push_back(mk(L, 8'h00, H, L, H, 8'hA3, H, 2'd1));
    tbl.push_back(mk(L, 8'h00, H, L, L, 8'h00, H, 2'd0));
    // bubble collapse under stall
    tbl.push_back(mk(H, 8'h10, L, L, L, 8'h00, H, 2'd0));
    tbl.push_back(mk(L, 8'h00, L, L, L, 8'h00, H, 2'd1));
    tbl.push_back(mk(L, 8'h00, L, L, L, 8'h00, H, 2'd1));
    tbl.push_back(mk(H, 8'h11, L, L, H, 8'h10, H, 2'd1));
    tbl.push_back(mk(L, 8'h00, L, L, H, 8'h10, H, 2'd2));
    tbl.push_back(mk(L, 8'h00, L, L, H, 8'h10, H, 2'd2));
    tbl.push_back(mk(L, 8'h00, H, L, H, 8'h10, H, 2'd2));
    tbl.push_back(mk(L, 8'h00, H, L, H, 8'h11, H, 2'd1));
    tbl.push_back(mk(L, 8'h00, H, L, L, 8'h00, H, 2'd0));
    // flush with a full pipe, then flush while empty
    tbl.push_back(mk(H, 8'h20, L, L, L, 8'h00, H, 2'd0));
    tbl.push_back(mk(H, 8'h21, L, L, L, 8'h00, H, 2'd1));
    tbl.push_back(mk(H, 8'h22, L, L, L, 8'h00, H, 2'd2));
    tbl.push_back(mk(H, 8'h23, H, H, H, 8'h20, L, 2'd3));
    tbl.push_back(mk(L, 8'h00, H, L, L, 8'h00, H, 2'd0));
    tbl.push_back(mk(L, 8'h00, H, L, L, 8'h00, H, 2'd0));
    tbl.push_back(mk(L, 8'h00, H, H, L, 8'h00, L, 2'd0));
    tbl.push_back(mk(L, 8'h00, H, L, L, 8'h00, H, 2'd0));

    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; data_in = 8'h00;
    flush0 = 1'b0; valid_in0 = 1'b0; ready_in0 = 1'b0; data_in0 = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset valid_o", 32'(valid_out), 32'd0);
    chk("reset occ_o", 32'(occ), 32'd0);
    chk("reset ready_o", 32'(ready_out), 32'd1);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      valid_in = tbl[i].v; data_in = tbl[i].d; ready_in = tbl[i].r; flush = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("row%0d valid_o", i), 32'(valid_out), 32'(tbl[i].ev));
      chk($sformatf("row%0d ready_o", i), 32'(ready_out), 32'(tbl[i].er));
      chk($sformatf("row%0d occ_o", i), 32'(occ), 32'(tbl[i].eo));
      if (tbl[i].ev) chk($sformatf("row%0d data_o", i), 32'(data_out), 32'(tbl[i].ed));
      @(posedge clk); #1;
    end

    // reset mid-stream discards in-flight beats
    flush = 1'b0; ready_in = 1'b0; valid_in = 1'b1; data_in = 8'h30;
    @(posedge clk); #1;
    data_in = 8'h31;
    @(posedge clk); #1;
    data_in = 8'h32;
    @(negedge clk);
    chk("pre-reset occ_o", 32'(occ), 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; valid_in = 1'b0;
    @(negedge clk);
    chk("midreset valid_o", 32'(valid_out), 32'd0);
    chk("midreset occ_o", 32'(occ), 32'd0);
    chk("midreset ready_o", 32'(ready_out), 32'd1);
`ifdef STREAM_PIPE_REG_DATA_RESET_EN
    chk("midreset data_o", 32'(data_out), 32'd0);
`endif
    // pipe works again after reset: 0x40 appears three cycles later
    @(posedge clk); #1;
    valid_in = 1'b1; data_in = 8'h40; ready_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post-reset valid_o", 32'(valid_out), 32'd1);
    chk("post-reset data_o", 32'(data_out), 32'h40);

    // Depth=0 pass-through
    for (int i = 0; i < 4; i++) begin
      valid_in0 = 1'b1;
      data_in0  = 8'h5A + 8'(i);
      ready_in0 = (i % 2 == 0);
      flush0    = (i == 3);
      #1;
      chk($sformatf("d0 step%0d valid_o", i), 32'(valid_out0), 32'd1);
      chk($sformatf("d0 step%0d data_o", i), 32'(data_out0), 32'h5A + 32'(i));
      chk($sformatf("d0 step%0d ready_o", i), 32'(ready_out0), 32'((i % 2 == 0) && (i != 3)));
      chk($sformatf("d0 step%0d occ_o", i), 32'(occ0), 32'd0);
    end
    valid_in0 = 1'b0; flush0 = 1'b0; ready_in0 = 1'b1;
    #1;
    chk("d0 idle valid_o", 32'(valid_out0), 32'd0);
    chk("d0 idle ready_o", 32'(ready_out0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
